regfile_loader: RTL and testbench
=================================

# regfile_loader

Host-side access port for the DSP core's register file. It accepts burst commands over a valid/ready word stream, drives the register file's write port for write bursts, and drives one read port for read bursts, returning read data over a second valid/ready stream. It sits between the host control link (SPI/bridge deframer) and the register file, and is used for coefficient load and readback while the core is idle.

## Interface

Parameters:
- REGADDR_WIDTH, 5, register address width; NUM_REGS = 1<<REGADDR_WIDTH
- DATA_WIDTH, 32, register and stream word width; must be ≥ 2*REGADDR_WIDTH+3
- COUNT_WIDTH, REGADDR_WIDTH+1, burst length field width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command/data word valid
- in_ready  out  1  loader accepts in_data this cycle
- in_data  in  DATA_WIDTH  header or write-data word
- out_valid  out  1  read-data word valid
- out_ready  in  1  sink accepts out_data
- out_data  out  DATA_WIDTH  read-data word
- writeAddr  out  REGADDR_WIDTH  register file write address
- dataW  out  DATA_WIDTH  register file write data
- writeEnable  out  1  register file write strobe, one cycle per word
- readAddr  out  REGADDR_WIDTH  register file read address
- dataR  in  DATA_WIDTH  register file read data, valid one posedge after readAddr
- busy  out  1  burst in progress (state ≠ IDLE)
- error  out  1  one-cycle pulse on illegal opcode

## Operation

- Header word fields: [1:0] opcode (01 = write, 10 = read, 00/11 = illegal); [REGADDR_WIDTH+1:2] start address; [REGADDR_WIDTH+COUNT_WIDTH+1:REGADDR_WIDTH+2] count; upper bits ignored.
- States: IDLE, WRITE, RD_ADDR, RD_CAP, RD_OUT.
- IDLE: in_ready=1. On handshake, latch addr and count.
  - Write with count>0 goes to WRITE; read with count>0 goes to RD_ADDR.
  - Count 0 is a no-op and stays in IDLE.
  - Illegal opcode: pulse error the next cycle, stay in IDLE, consume the word.
- WRITE: in_ready=1. Each handshake registers writeAddr=addr, dataW=in_data, writeEnable=1 for exactly the next cycle. Then addr+1, count−1. After the last word, go to IDLE.
- RD_ADDR: readAddr=addr. Go to RD_CAP.
- RD_CAP: capture dataR into out_data, set out_valid. Go to RD_OUT.
- RD_OUT: hold out_data and out_valid until out_ready.
  - On handshake, clear out_valid, addr+1, count−1.
  - Go to RD_ADDR if count remains, else IDLE.
- in_ready=0 in all read states. Input words are never dropped while in_ready=0.
- Address increments modulo NUM_REGS. A burst crossing the top address wraps to 0.
- Writes to address 0 are issued normally. Readback of address 0 returns 0, because the register file forces register 0 to read as 0.
- readAddr holds its last value outside RD_ADDR/RD_CAP.

## Timing

- Reset (rst_n low, asynchronous): state IDLE; in_ready=0 while rst_n low, then 1 from the first posedge after release. out_valid=0, out_data=0, writeEnable=0, writeAddr=0, dataW=0, readAddr=0, busy=0, error=0.
- Reset mid-burst aborts the burst immediately. The remaining count is discarded and no further writeEnable is issued.
- Write latency: data accepted at posedge N produces writeEnable high during cycle N+1. The register file commits at the negedge within that cycle. Sustained throughput is 1 word/cycle.
- Read latency: header accepted at posedge N gives first out_valid at N+3. Each subsequent word comes ≥3 cycles after the previous out handshake. With out_ready held high, throughput is 1 word per 3 cycles.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- busy=1 from the cycle after header acceptance until the cycle after the final write word or final read handshake.
- A header may be accepted in the cycle after the last write word; back-to-back bursts are allowed.
- Writes and reads never overlap, so there is no read-during-write hazard.

## Test plan

- Reset then write burst: header {op=01, addr=3, count=4}, data 0xA0..0xA3 with in_valid held → writeEnable on 4 consecutive cycles, writeAddr 3,4,5,6, dataW 0xA0..0xA3; busy drops after the last write.
- Read back the same region: header {op=10, addr=3, count=4}, out_ready=1 → out_data 0xA0..0xA3, first out_valid 3 cycles after the header, then one word per 3 cycles.
- Wrap and register 0: write {addr=30, count=3} with 0x11,0x22,0x33 → writeAddr 30,31,0. Read the same → 0x11,0x22,0x00.
- Backpressure: read count=2 with out_ready low for 5 cycles → out_valid stays high and out_data stays stable, in_ready=0 throughout; the second word follows only after the handshake.
- Illegal and zero-count headers: opcode 11 → single error pulse, no writeEnable. Write with count 0 → no activity, busy stays 0. The next valid header is accepted normally.
- Reset mid-burst: assert rst_n low after 2 of 4 write words → all outputs go to reset values asynchronously; after release, no stray writeEnable and in_ready=1.

Source files
------------

// File: rtl/regfile_loader.sv
// Host-side burst loader for the DSP register file: write bursts drive the write
// port, read bursts fetch one word at a time onto a valid/ready output stream.
module regfile_loader #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = REGADDR_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic [REGADDR_WIDTH-1:0] writeAddr_o,
  output logic [DATA_WIDTH-1:0]    dataW_o,
  output logic                     writeEnable_o,
  output logic [REGADDR_WIDTH-1:0] readAddr_o,
  input  logic [DATA_WIDTH-1:0]    dataR_i,
  output logic                     busy_o,
  output logic                     error_o
);

  localparam int CNT_LSB = REGADDR_WIDTH + 2;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [REGADDR_WIDTH-1:0] ADDR_ONE  = REGADDR_WIDTH'(1'b1);
  localparam logic [REGADDR_WIDTH-1:0] ADDR_ZERO = {REGADDR_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0]   CNT_ONE   = COUNT_WIDTH'(1'b1);
  localparam logic [COUNT_WIDTH-1:0]   CNT_ZERO  = {COUNT_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_RD_OUT  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [REGADDR_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [REGADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     we_q, we_d;
  logic [REGADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q, err_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic                     in_hs_s;
  logic [1:0]               hdr_op_s;
  logic [REGADDR_WIDTH-1:0] hdr_addr_s;
  logic [COUNT_WIDTH-1:0]   hdr_cnt_s;

  assign in_hs_s    = in_valid_i & in_ready_q;
  assign hdr_op_s   = in_data_i[1:0];
  assign hdr_addr_s = in_data_i[CNT_LSB-1:2];
  assign hdr_cnt_s  = in_data_i[CNT_LSB+COUNT_WIDTH-1:CNT_LSB];

  // Burst sequencing: next state plus every registered output's next value
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) begin
          addr_d = hdr_addr_s;
          cnt_d  = hdr_cnt_s;
          if (hdr_op_s == OP_WRITE) begin
            state_d = (hdr_cnt_s != CNT_ZERO) ? ST_WRITE : ST_IDLE;
          end else if (hdr_op_s == OP_READ) begin
            if (hdr_cnt_s != CNT_ZERO) begin
              state_d   = ST_RD_ADDR;
              rd_addr_d = hdr_addr_s;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (in_hs_s) begin
          we_d      = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data_i;
          addr_d    = addr_q + ADDR_ONE;
          cnt_d     = cnt_q - CNT_ONE;
          state_d   = (cnt_q == CNT_ONE) ? ST_IDLE : ST_WRITE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      // readAddr was presented on entry, so dataR is valid by the following cycle
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        out_data_d  = dataR_i;
        out_valid_d = 1'b1;
        state_d     = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + ADDR_ONE;
          cnt_d       = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_RD_ADDR;
            rd_addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_RD_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= ADDR_ZERO;
      cnt_q       <= CNT_ZERO;
      wr_addr_q   <= ADDR_ZERO;
      wr_data_q   <= DATA_ZERO;
      we_q        <= 1'b0;
      rd_addr_q   <= ADDR_ZERO;
      out_data_q  <= DATA_ZERO;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign writeAddr_o   = wr_addr_q;
  assign dataW_o       = wr_data_q;
  assign writeEnable_o = we_q;
  assign readAddr_o    = rd_addr_q;
  assign busy_o        = busy_q;
  assign error_o       = err_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: directed bursts plus random traffic against a
// register-array reference model, with a queue scoreboard checked by a monitor.
module tb_regfile_loader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] dataW;
  logic          writeEnable;
  logic [AW-1:0] readAddr;
  logic [DW-1:0] dataR = 32'd0;
  logic          busy;
  logic          error;

  regfile_loader #(.REGADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(AW+1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .writeAddr_o(writeAddr), .dataW_o(dataW), .writeEnable_o(writeEnable),
    .readAddr_o(readAddr), .dataR_i(dataR), .busy_o(busy), .error_o(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in: commit on negedge, synchronous read, r0 reads 0
  logic [DW-1:0] rf_mem [NR];
  always @(negedge clk) if (writeEnable) rf_mem[writeAddr] <= dataW;
  always @(posedge clk) dataR <= (readAddr == 5'd0) ? 32'd0 : rf_mem[readAddr];

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic first; int hdr_cyc; } rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  int      err_q[$];

  logic       rdy_mode = 1'b0;
  logic       rdy_force = 1'b1;
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, read word or error
  int            last_in_hs = -100;
  int            last_out_hs = -100;
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [DW-1:0] prev_d = 32'd0;
  initial begin
    wr_exp_t we;
    rd_exp_t re;
    int      ee;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (writeEnable) begin
          if (wr_q.size() == 0) check("we_unexpected", 32'(writeEnable), 32'd0);
          else begin
            we = wr_q.pop_front();
            check("wr_addr", 32'(writeAddr), 32'(we.addr));
            check("wr_data", dataW, we.data);
            check("wr_latency", 32'(cyc), 32'(last_in_hs));
          end
        end
        if (prev_v && !prev_r) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", out_data, prev_d);
        end
        if (out_valid && !prev_v) begin
          if (rd_q.size() == 0) check("rd_unexpected", 32'(out_valid), 32'd0);
          else if (rd_q[0].first) check("rd_first_latency", 32'(cyc + 1 - rd_q[0].hdr_cyc), 32'd3);
          else check("rd_gap_ge3", 32'((cyc + 1 - last_out_hs) >= 3), 32'd1);
        end
        if (out_valid && out_ready) begin
          if (rd_q.size() != 0) begin
            re = rd_q.pop_front();
            check("rd_data", out_data, re.data);
          end
          last_out_hs = cyc + 1;
        end
        if (error) begin
          if (err_q.size() == 0) check("err_unexpected", 32'(error), 32'd0);
          else begin
            ee = err_q.pop_front();
            check("err_timing", 32'(cyc), 32'(ee));
          end
        end
        if (in_valid && in_ready) last_in_hs = cyc + 1;
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
      end
    end
  end

  // Reference model: plain register array, addresses taken modulo NUM_REGS
  logic [DW-1:0] ref_mem [NR];
  logic [DW-1:0] wd[$];

  function automatic logic [31:0] mk_hdr(input logic [1:0] op, input int a, input int n,
                                         input logic [31:0] junk);
    logic [31:0] h;
    h = junk;
    h[1:0] = op;
    h[6:2] = a[4:0];
    h[12:7] = n[5:0];
    return h;
  endfunction

  task automatic send_word(input logic [31:0] w, output int hs);
    int n = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    check("in_accept", 32'(in_ready), 32'd1);
    hs = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] junk);
    int hs, idx;
    wr_exp_t e;
    for (int i = 0; i < wd.size(); i++) begin
      idx = (a + i) % NR;
      ref_mem[idx] = wd[i];
      e.addr = idx[AW-1:0];
      e.data = wd[i];
      wr_q.push_back(e);
    end
    send_word(mk_hdr(2'b01, a, wd.size(), junk), hs);
    check("busy_after_wr_hdr", 32'(busy), 32'(wd.size() != 0));
    for (int i = 0; i < wd.size(); i++) send_word(wd[i], hs);
    check("busy_after_wr_end", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input int a, input int n, input logic [31:0] junk);
    int hs, idx;
    rd_exp_t e;
    send_word(mk_hdr(2'b10, a, n, junk), hs);
    check("busy_after_rd_hdr", 32'(busy), 32'(n != 0));
    for (int i = 0; i < n; i++) begin
      idx = (a + i) % NR;
      e.data = (idx == 0) ? 32'd0 : ref_mem[idx];
      e.first = (i == 0);
      e.hdr_cyc = hs;
      rd_q.push_back(e);
    end
  endtask

  task automatic do_illegal(input logic [1:0] op, input logic [31:0] junk);
    int hs;
    send_word(mk_hdr(op, $urandom_range(0, NR - 1), $urandom_range(0, 8), junk), hs);
    err_q.push_back(hs);
  endtask

  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0 || err_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", 32'(n < 3000), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_we"}, 32'(writeEnable), 32'd0);
    check({tag, "_waddr"}, 32'(writeAddr), 32'd0);
    check({tag, "_dataW"}, dataW, 32'd0);
    check({tag, "_raddr"}, 32'(readAddr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int hs, kind, a, n;
    wr_exp_t e;
    for (int i = 0; i < NR; i++) ref_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Write burst then readback, ready held high
    wd.delete();
    for (int i = 0; i < 4; i++) wd.push_back(32'hA0 + 32'(i));
    do_write(3, 32'd0);
    do_read(3, 4, 32'd0);
    drain();

    // Wrap through the top address and register 0
    wd.delete();
    wd.push_back(32'h11); wd.push_back(32'h22); wd.push_back(32'h33);
    do_write(30, 32'd0);
    do_read(30, 3, 32'd0);
    drain();

    // Backpressure: sink stalls for five cycles on the first word
    rdy_force = 1'b0;
    do_read(3, 2, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    rdy_force = 1'b1;
    drain();

    // Illegal opcodes and zero-count headers, then a normal burst
    do_illegal(2'b11, 32'd0);
    do_illegal(2'b00, 32'd0);
    wd.delete();
    do_write(5, 32'd0);
    do_read(5, 0, 32'd0);
    wd.push_back(32'hDEADBEEF);
    do_write(9, 32'd0);
    do_read(9, 1, 32'd0);
    drain();

    // Reset after two of four write words
    for (int i = 0; i < 2; i++) begin
      ref_mem[12 + i] = 32'hC0DE0000 + 32'(i);
      e.addr = 5'(12 + i);
      e.data = ref_mem[12 + i];
      wr_q.push_back(e);
    end
    send_word(mk_hdr(2'b01, 12, 4, 32'd0), hs);
    send_word(32'hC0DE0000, hs);
    send_word(32'hC0DE0001, hs);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_we", 32'(writeEnable), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    // Fill every register, then random traffic with random sink readiness
    wd.delete();
    for (int i = 0; i < NR; i++) wd.push_back($urandom);
    do_write(0, 32'd0);
    rdy_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, NR - 1);
      n = $urandom_range(1, 8);
      if (kind < 4) begin
        wd.delete();
        for (int i = 0; i < n; i++) wd.push_back($urandom);
        do_write(a, $urandom);
      end else if (kind < 8) begin
        do_read(a, n, $urandom);
      end else if (kind == 8) begin
        do_illegal($urandom_range(0, 1) == 0 ? 2'b00 : 2'b11, $urandom);
      end else begin
        wd.delete();
        do_write(a, $urandom);
      end
    end
    drain();
    rdy_mode = 1'b0;

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
